// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, branch redirect input,
// and the valid/ready instruction handshake toward decode.
interface fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rd_en;
  logic [DATA_W-1:0] imem_data;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output imem_addr, imem_rd_en,
    output instr_valid, instr, instr_pc,
    input  imem_data, branch_valid,
    input  branch_target, instr_ready
  );

  modport slave (
    input  imem_addr, imem_rd_en,
    input  instr_valid, instr, instr_pc,
    output imem_data, branch_valid,
    output branch_target, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, 1-cycle imem reads, small FIFO to decode.
// Define FETCH_PERF_EN to add perf_fetched/perf_stall/perf_flush counters.
module fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 2,
  parameter int PC_STEP = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stall,
  output logic [31:0]  perf_flush
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic              r_infl;
  logic [ADDR_W-1:0] r_infl_pc;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [ADDR_W-1:0] r_pcq  [DEPTH];

  logic              w_run;
  logic              w_brk;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_req;
  logic [CW:0]       w_occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_run   = (r_state == S_RUN);
  assign w_brk   = w_run & bus.branch_valid;
  assign w_valid = (r_cnt != '0);
  assign w_pop   = w_valid & bus.instr_ready & ~w_brk;
  assign w_push  = r_infl & ~w_brk;

  // Credit the slot freed by this cycle's pop so a full-rate stream never bubbles
  assign w_occ = {1'b0, r_cnt}
               + {{CW{1'b0}}, r_infl}
               - {{CW{1'b0}}, w_pop};
  assign w_req = w_run & ~bus.branch_valid
               & (w_occ < (CW+1)'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= '0;
      r_infl    <= 1'b0;
      r_infl_pc <= '0;
      r_cnt     <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
    end else begin
      r_infl <= w_req;
      if (w_req) r_infl_pc <= r_pc;
      if (w_brk) begin
        r_pc  <= bus.branch_target;
        r_cnt <= '0;
        r_wp  <= '0;
        r_rp  <= '0;
      end else begin
        if (w_req)  r_pc <= r_pc + ADDR_W'(PC_STEP);
        if (w_push) r_wp <= r_wp + PW'(1);
        if (w_pop)  r_rp <= r_rp + PW'(1);
        r_cnt <= r_cnt
               + {{PW{1'b0}}, w_push}
               - {{PW{1'b0}}, w_pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wp] <= bus.imem_data;
      r_pcq[r_wp]  <= r_infl_pc;
    end
  end

  assign bus.imem_rd_en  = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = w_valid;
  assign bus.instr       = w_valid ? r_data[r_rp] : '0;
  assign bus.instr_pc    = w_valid ? r_pcq[r_rp]  : '0;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flush   <= '0;
    end else begin
      if (w_push) perf_fetched <= perf_fetched + 32'd1;
      if (w_valid & ~bus.instr_ready)
        perf_stall <= perf_stall + 32'd1;
      if (w_brk) perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle-exact vector table, async reset sequence,
// then randomized ready/branch traffic against an in-order PC stream model.
module tb_fetch_unit;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  fetch_unit #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(2), .PC_STEP(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bus(bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall(perf_stall),
    .perf_flush(perf_flush)
`endif
  );

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return 32'hE000_0000 | {24'h0, a};
  endfunction

  // Clocked instruction memory: word for the address appears next cycle
  always @(posedge clk)
    if (bus.imem_rd_en) bus.imem_data <= word(bus.imem_addr);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic           st;
    logic           br;
    logic [AW-1:0]  tgt;
    logic           rdy;
    logic           e_rd;
    logic [AW-1:0]  e_addr;
    logic           e_val;
    logic [AW-1:0]  e_pc;
  } vec_t;

  function automatic vec_t mk(logic st, logic br, logic [AW-1:0] tgt,
                              logic rdy, logic e_rd, logic [AW-1:0] e_addr,
                              logic e_val, logic [AW-1:0] e_pc);
    vec_t v;
    v.st = st; v.br = br; v.tgt = tgt; v.rdy = rdy;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc;
    return v;
  endfunction

  vec_t tv[$];

  task automatic drive_idle();
    start = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = '0;
    bus.instr_ready   = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic e_rd,
                            input logic [AW-1:0] e_addr, input logic e_val,
                            input logic [AW-1:0] e_pc);
    logic [DW-1:0] e_ins;
    e_ins = e_val ? word(e_pc) : '0;
    chk({tag, " rd_en"}, 32'(bus.imem_rd_en), 32'(e_rd));
    chk({tag, " addr"},  32'(bus.imem_addr),  32'(e_addr));
    chk({tag, " valid"}, 32'(bus.instr_valid), 32'(e_val));
    chk({tag, " pc"},    32'(bus.instr_pc),   32'(e_pc));
    chk({tag, " instr"}, bus.instr,           e_ins);
  endtask

  logic [AW-1:0] mpc;
  int pushes, stalls, flushes, pops;
  logic p_rd, p_hold, p_br;
  logic [AW-1:0] p_pc;
  logic [DW-1:0] p_ins;

  initial begin
    rst = 1'b1;
    drive_idle();

    // start cycle = row 1; branch in IDLE (row 0) must be ignored
    tv.push_back(mk(0,1,8'h80,1, 0,8'h00,0,8'h00));
    tv.push_back(mk(1,0,8'h00,1, 0,8'h00,0,8'h00));
    tv.push_back(mk(0,0,8'h00,1, 1,8'h00,0,8'h00));
    tv.push_back(mk(0,0,8'h00,0, 1,8'h04,0,8'h00));
    tv.push_back(mk(0,0,8'h00,0, 0,8'h08,1,8'h00));
    tv.push_back(mk(0,0,8'h00,0, 0,8'h08,1,8'h00));
    tv.push_back(mk(0,0,8'h00,0, 0,8'h08,1,8'h00));
    tv.push_back(mk(0,0,8'h00,0, 0,8'h08,1,8'h00));
    tv.push_back(mk(0,0,8'h00,1, 1,8'h08,1,8'h00));
    tv.push_back(mk(0,0,8'h00,1, 1,8'h0C,1,8'h04));
    tv.push_back(mk(0,0,8'h00,1, 1,8'h10,1,8'h08));
    tv.push_back(mk(0,1,8'h40,1, 0,8'h14,1,8'h0C));
    tv.push_back(mk(0,0,8'h00,1, 1,8'h40,0,8'h00));
    tv.push_back(mk(0,0,8'h00,1, 1,8'h44,0,8'h00));
    tv.push_back(mk(0,0,8'h00,1, 1,8'h48,1,8'h40));
    tv.push_back(mk(0,1,8'hF8,1, 0,8'h4C,1,8'h44));
    tv.push_back(mk(0,0,8'h00,1, 1,8'hF8,0,8'h00));
    tv.push_back(mk(0,0,8'h00,1, 1,8'hFC,0,8'h00));
    tv.push_back(mk(0,0,8'h00,1, 1,8'h00,1,8'hF8));
    tv.push_back(mk(0,0,8'h00,1, 1,8'h04,1,8'hFC));
    tv.push_back(mk(0,0,8'h00,1, 1,8'h08,1,8'h00));
    tv.push_back(mk(0,0,8'h00,1, 1,8'h0C,1,8'h04));

    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      start             = tv[i].st;
      bus.branch_valid  = tv[i].br;
      bus.branch_target = tv[i].tgt;
      bus.instr_ready   = tv[i].rdy;
      #1;
      check_outs($sformatf("vec%0d", i), tv[i].e_rd, tv[i].e_addr,
                 tv[i].e_val, tv[i].e_pc);
`ifdef FETCH_PERF_EN
      if (i == 8)  chk("perf_stall after hold", perf_stall, 32'd4);
      if (i == 12) chk("perf_flush after branch", perf_flush, 32'd1);
`endif
    end

    // Async reset between edges with a fetch in flight
    @(negedge clk);
    drive_idle();
    bus.instr_ready = 1'b1;
    #2 rst = 1'b1;
    #1 check_outs("async rst", 1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check_outs($sformatf("post rst idle%0d", i), 1'b0, 8'h00,
                    1'b0, 8'h00);
    end
    @(negedge clk);
    start = 1'b1;
    #1 check_outs("restart c0", 1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    start = 1'b0;
    #1 check_outs("restart c1", 1'b1, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    #1 check_outs("restart c2", 1'b1, 8'h04, 1'b0, 8'h00);
    @(negedge clk);
    #1 check_outs("restart c3", 1'b1, 8'h08, 1'b1, 8'h00);

    // Randomized traffic
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    mpc = '0;
    pushes = 0; stalls = 0; flushes = 0; pops = 0;
    p_rd = 1'b0; p_hold = 1'b0; p_br = 1'b0;
    p_pc = '0; p_ins = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start             = 1'b0;
      bus.branch_valid  = ($urandom_range(0, 19) == 0);
      bus.branch_target = AW'($urandom);
      bus.instr_ready   = ($urandom_range(0, 3) != 0);
      #1;
      if (p_rd && !bus.branch_valid) pushes++;
      if (bus.instr_valid && !bus.instr_ready) stalls++;
      if (bus.branch_valid) flushes++;
      if (p_br) chk("valid after branch", 32'(bus.instr_valid), 32'd0);
      if (p_hold) begin
        chk("hold valid", 32'(bus.instr_valid), 32'd1);
        chk("hold pc", 32'(bus.instr_pc), 32'(p_pc));
        chk("hold instr", bus.instr, p_ins);
      end
      if (bus.instr_valid && bus.instr_ready && !bus.branch_valid) begin
        chk("pop pc", 32'(bus.instr_pc), 32'(mpc));
        chk("pop instr", bus.instr, word(mpc));
        mpc = mpc + AW'(4);
        pops++;
      end
      if (bus.branch_valid) mpc = bus.branch_target;
      p_hold = bus.instr_valid && !bus.instr_ready && !bus.branch_valid;
      p_pc   = mpc;
      p_ins  = word(mpc);
      p_br   = bus.branch_valid;
      p_rd   = bus.imem_rd_en;
    end
    @(negedge clk);
    drive_idle();
    #1;
    chk("random progress", 32'(pops > 800), 32'd1);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'(pushes));
    chk("perf_stall", perf_stall, 32'(stalls));
    chk("perf_flush", perf_flush, 32'(flushes));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
